controller_uart1_baud_gen: RTL

Baud tick generator for UART1. It consumes the 22-bit baud divisor produced by the UART1 baud-control PIO and generates the timing strobes for the UART1 transmitter and receiver: a 16x oversample tick, a mid-bit sample tick and a bit-boundary tick. A phase accumulator keeps exactly `divisor` clocks per bit, including divisors that are not multiples of 16. A divisor written by software takes effect only at a bit boundary, on resync, or while the generator is idle, so a character already in flight is never corrupted.

---
 rtl/controller_uart1_baud_gen.sv | 95 +++++++++
 1 files changed

// File: rtl/controller_uart1_baud_gen.sv
// UART1 baud tick generator: a phase accumulator that produces 16x oversample,
// bit-centre and bit-boundary strobes with exactly div_q clocks per bit.
module controller_uart1_baud_gen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [21:0] divisor_in,
    input  logic        enable,
    input  logic        resync,
    output logic        os_tick,
    output logic        mid_tick,
    output logic        bit_tick,
    output logic        active,
    output logic [21:0] div_active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [21:0] div_q;
    logic [22:0] acc;
    logic [3:0]  os_cnt;

    logic [22:0] d_eff;
    logic [22:0] sum;
    logic        tick_hit;

    // Divisors below 32 are clamped so os_tick is never high on consecutive cycles.
    always_comb begin
        d_eff    = (div_q < 22'd32) ? 23'd32 : {1'b0, div_q};
        sum      = acc + 23'd16;
        tick_hit = (sum >= d_eff);
    end

    // Strobes are single-cycle pulses with no handshake: consumers must sample
    // them on every clock; mid_tick and bit_tick only ever coincide with os_tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div_q    <= 22'd0;
            acc      <= 23'd0;
            os_cnt   <= 4'd0;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            case (state)
                IDLE: begin
                    div_q  <= divisor_in;
                    acc    <= 23'd0;
                    os_cnt <= 4'd0;
                    if (enable && (divisor_in != 22'd0)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state  <= IDLE;
                        acc    <= 23'd0;
                        os_cnt <= 4'd0;
                    end else if (resync) begin
                        acc    <= 23'd0;
                        os_cnt <= 4'd0;
                        div_q  <= divisor_in;
                    end else if (tick_hit) begin
                        acc      <= sum - d_eff;
                        os_cnt   <= os_cnt + 4'd1;
                        os_tick  <= 1'b1;
                        mid_tick <= (os_cnt == 4'd7);
                        bit_tick <= (os_cnt == 4'd15);
                        // acc is exactly 0 here, so a new divisor starts on a clean phase.
                        if (os_cnt == 4'd15) begin
                            div_q <= divisor_in;
                            if (divisor_in == 22'd0) begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        acc <= sum;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign active     = (state == RUN);
    assign div_active = div_q;

endmodule
